gfx_vram_arb: RTL

GFX_VRAM_ARB -- requirements
Module: gfx_vram_arb

---
 rtl/gfx_vram_arb_pkg.sv | 25 ++
 rtl/gfx_vram_arb.sv | 120 ++++++++++++
 2 files changed

// File: rtl/gfx_vram_arb_pkg.sv
// gfx_vram_arb_pkg
// Shared constants for the graphics VRAM read-port arbiter.
//   - Requester index constants (tile, sprite, bitmap/DMA).
//   - Default VRAM address and data widths.
//   - Round-robin pointer encoding and the saturation value of the
//     requester-2 wait counter.
package gfx_vram_arb_pkg;

  localparam int GFX_ADDR_W = 14;
  localparam int GFX_DATA_W = 16;

  localparam int REQ_TILE = 0;
  localparam int REQ_SPR  = 1;
  localparam int REQ_DMA  = 2;
  localparam int NUM_REQ  = 3;

  // Which of requesters 1/2 wins the next round-robin contest.
  typedef enum logic {
    RR_SPR = 1'b0,
    RR_DMA = 1'b1
  } rr_ptr_e;

  localparam logic [3:0] STARVE_MAX = 4'hF;

endpackage

// File: rtl/gfx_vram_arb.sv
// gfx_vram_arb
// Three-way arbiter for the single VRAM read port, clocked by the pixel clock.
// Ports:
//   clk        pixel clock, the only clock
//   reset_n    synchronous active-low reset
//   req[2:0]   read requests: 0 tile fetch, 1 sprite fetch, 2 bitmap/DMA
//   lock1      lets requester 1 keep the port for back-to-back grants
//   addr0..2   per-requester word address
//   gnt[2:0]   one-hot-or-zero grant, combinational in the request cycle
//   rvalid     one-hot-or-zero read-data valid, one cycle after gnt
//   rdata      read data (straight copy of vdata)
//   vaddr      VRAM read address of the granted requester, 0 when idle
//   vdata      VRAM read data, valid one cycle after vaddr is sampled
//   starve_cnt requester-2 wait count (debug view of internal state)
//
// Handshake: a requester raises req[N] with a stable addrN and holds both
// until it sees gnt[N] high in a cycle; that cycle is the transfer. req[N]
// may stay high to request again immediately. Data for that grant appears
// with rvalid[N] exactly one cycle later. No back-pressure on the data side.
module gfx_vram_arb
  import gfx_vram_arb_pkg::*;
#(
  parameter int ADDR_W       = GFX_ADDR_W,
  parameter int DATA_W       = GFX_DATA_W,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        req,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  output logic [2:0]        gnt,
  output logic [2:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] vaddr,
  input  logic [DATA_W-1:0] vdata,
  output logic [3:0]        starve_cnt
);

  // A limit above the counter's saturation value means requester 2 is
  // never promoted.
  localparam logic [31:0] STARVE_LIM_U = STARVE_LIMIT;

  rr_ptr_e     rr_ptr;
  logic        lock_q;
  logic [3:0]  starve_q;
  logic [2:0]  gnt_q;

  logic [2:0]  gnt_c;
  logic        rr_tier;
  logic        promote;
  logic        lock_win;

  // Grant decode and address mux.
  always_comb begin
    gnt_c    = '0;
    rr_tier  = 1'b0;
    vaddr    = '0;
    promote  = req[REQ_DMA] && ({28'd0, starve_q} >= STARVE_LIM_U);
    // lock1 dropping ends the lock in that same cycle, so it must be high
    // now as well as having been high at the locking grant.
    lock_win = lock_q && req[REQ_SPR] && lock1;

    if (reset_n) begin
      if (promote) begin
        gnt_c[REQ_DMA] = 1'b1;
      end else if (lock_win) begin
        gnt_c[REQ_SPR] = 1'b1;
      end else if (req[REQ_TILE]) begin
        gnt_c[REQ_TILE] = 1'b1;
      end else if (req[REQ_SPR] && req[REQ_DMA]) begin
        rr_tier = 1'b1;
        if (rr_ptr == RR_SPR) gnt_c[REQ_SPR] = 1'b1;
        else                  gnt_c[REQ_DMA] = 1'b1;
      end else if (req[REQ_SPR]) begin
        rr_tier        = 1'b1;
        gnt_c[REQ_SPR] = 1'b1;
      end else if (req[REQ_DMA]) begin
        rr_tier        = 1'b1;
        gnt_c[REQ_DMA] = 1'b1;
      end
    end

    if (gnt_c[REQ_TILE])     vaddr = addr0;
    else if (gnt_c[REQ_SPR]) vaddr = addr1;
    else if (gnt_c[REQ_DMA]) vaddr = addr2;
  end

  // Pointer, lock, starvation counter and registered grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr   <= RR_SPR;
      lock_q   <= 1'b0;
      starve_q <= '0;
      gnt_q    <= '0;
    end else begin
      gnt_q <= gnt_c;

      // After a round-robin win the other requester is favoured; with both
      // contending this is a toggle, with one alone it is a no-op or a toggle.
      if (rr_tier) begin
        rr_ptr <= gnt_c[REQ_SPR] ? RR_DMA : RR_SPR;
      end

      if (gnt_c[REQ_SPR] && lock1)      lock_q <= 1'b1;
      else if (!req[REQ_SPR] || !lock1) lock_q <= 1'b0;

      if (gnt_c[REQ_DMA] || !req[REQ_DMA]) starve_q <= '0;
      else if (starve_q != STARVE_MAX)     starve_q <= starve_q + 4'd1;
    end
  end

  assign gnt        = gnt_c;
  assign rvalid     = gnt_q;
  assign rdata      = vdata;
  assign starve_cnt = starve_q;

endmodule
